// File: rtl/alsu_pkg.sv
// Shared definitions for the ALSU request/response driver: widths, opcodes,
// FSM state encoding and the registered ALSU pin bundle.
package alsu_pkg;

   localparam int OPND_W = 3;
   localparam int RES_W  = 6;
   localparam int LED_W  = 16;
   localparam int OPC_W  = 3;

   localparam logic [OPC_W-1:0] OP_OR     = 3'd0;
   localparam logic [OPC_W-1:0] OP_XOR    = 3'd1;
   localparam logic [OPC_W-1:0] OP_ADD    = 3'd2;
   localparam logic [OPC_W-1:0] OP_MUL    = 3'd3;
   localparam logic [OPC_W-1:0] OP_SHIFT  = 3'd4;
   localparam logic [OPC_W-1:0] OP_ROTATE = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_WAIT    = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_RESP    = 3'd4
   } state_e;

   typedef struct packed {
      logic signed [OPND_W-1:0] a;
      logic signed [OPND_W-1:0] b;
      logic [OPC_W-1:0]         opcode;
      logic                     cin;
      logic                     serial_in;
      logic                     red_op_a;
      logic                     red_op_b;
      logic                     bypass_a;
      logic                     bypass_b;
      logic                     direction;
   } alsu_pins_t;

endpackage

// File: rtl/alsu_invalid_chk.sv
// Local decode of ALSU requests that the ALSU itself treats as invalid:
// reductions on non-logic opcodes, and the two unused opcodes 6 and 7.
module alsu_invalid_chk
   import alsu_pkg::*;
(
   input  logic [OPC_W-1:0] opcode,
   input  logic             red_op_a,
   input  logic             red_op_b,
   output logic             invalid
);

   assign invalid = ((red_op_a | red_op_b) & (opcode[1] | opcode[2]))
                  | (opcode[1] & opcode[2]);

endmodule

// File: rtl/alsu_driver.sv
// Single-outstanding request driver for the ALSU: drives registered pins,
// waits out the ALSU's two register stages, captures the result and holds it
// for a valid/ready consumer.
module alsu_driver
   import alsu_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [OPC_W-1:0]         req_opcode,
   input  logic signed [OPND_W-1:0] req_a,
   input  logic signed [OPND_W-1:0] req_b,
   input  logic                     req_cin,
   input  logic                     req_serial_in,
   input  logic                     req_red_op_a,
   input  logic                     req_red_op_b,
   input  logic                     req_bypass_a,
   input  logic                     req_bypass_b,
   input  logic                     req_direction,
   output logic signed [OPND_W-1:0] alsu_A,
   output logic signed [OPND_W-1:0] alsu_B,
   output logic [OPC_W-1:0]         alsu_opcode,
   output logic                     alsu_cin,
   output logic                     alsu_serial_in,
   output logic                     alsu_red_op_A,
   output logic                     alsu_red_op_B,
   output logic                     alsu_bypass_A,
   output logic                     alsu_bypass_B,
   output logic                     alsu_direction,
   input  logic signed [RES_W-1:0]  alsu_out,
   input  logic [LED_W-1:0]         alsu_leds,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic signed [RES_W-1:0]  rsp_data,
   output logic                     rsp_invalid,
   output logic                     rsp_leds_on,
   output logic [7:0]               op_count,
   output logic [7:0]               invalid_count,
   output state_e                   dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready.
   // rsp_valid/rsp_data/rsp_invalid/rsp_leds_on stay stable until accepted.

   state_e                  state_q, state_d;
   alsu_pins_t              pins_q, pins_d, req_pins;
   logic                    inv_q, inv_d;
   logic                    req_invalid;
   logic signed [RES_W-1:0] rsp_data_q, rsp_data_d;
   logic                    rsp_invalid_q, rsp_invalid_d;
   logic                    rsp_leds_on_q, rsp_leds_on_d;
   logic [7:0]              op_count_q, op_count_d;
   logic [7:0]              invalid_count_q, invalid_count_d;

   alsu_invalid_chk u_invalid_chk (
      .opcode   (req_opcode),
      .red_op_a (req_red_op_a),
      .red_op_b (req_red_op_b),
      .invalid  (req_invalid)
   );

   always_comb begin
      req_pins.a         = req_a;
      req_pins.b         = req_b;
      req_pins.opcode    = req_opcode;
      req_pins.cin       = req_cin;
      req_pins.serial_in = req_serial_in;
      req_pins.red_op_a  = req_red_op_a;
      req_pins.red_op_b  = req_red_op_b;
      req_pins.bypass_a  = req_bypass_a;
      req_pins.bypass_b  = req_bypass_b;
      req_pins.direction = req_direction;
   end

   // Held low throughout reset so nothing is offered the idea of acceptance.
   assign req_ready = rst & (state_q == ST_IDLE);

   always_comb begin
      state_d         = state_q;
      pins_d          = pins_q;
      inv_d           = inv_q;
      rsp_data_d      = rsp_data_q;
      rsp_invalid_d   = rsp_invalid_q;
      rsp_leds_on_d   = rsp_leds_on_q;
      op_count_d      = op_count_q;
      invalid_count_d = invalid_count_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready) begin
               state_d = ST_ISSUE;
               pins_d  = req_pins;
               inv_d   = req_invalid;
            end
         end
         ST_ISSUE:   state_d = ST_WAIT;
         ST_WAIT:    state_d = ST_CAPTURE;
         ST_CAPTURE: begin
            // ALSU output register now reflects the pins loaded at accept.
            state_d       = ST_RESP;
            rsp_data_d    = alsu_out;
            rsp_leds_on_d = |alsu_leds;
            rsp_invalid_d = inv_q;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d    = ST_IDLE;
               op_count_d = op_count_q + 8'd1;
               if (rsp_invalid_q && (invalid_count_q != 8'hFF)) begin
                  invalid_count_d = invalid_count_q + 8'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= ST_IDLE;
         pins_q          <= '0;
         inv_q           <= 1'b0;
         rsp_data_q      <= '0;
         rsp_invalid_q   <= 1'b0;
         rsp_leds_on_q   <= 1'b0;
         op_count_q      <= 8'd0;
         invalid_count_q <= 8'd0;
      end else begin
         state_q         <= state_d;
         pins_q          <= pins_d;
         inv_q           <= inv_d;
         rsp_data_q      <= rsp_data_d;
         rsp_invalid_q   <= rsp_invalid_d;
         rsp_leds_on_q   <= rsp_leds_on_d;
         op_count_q      <= op_count_d;
         invalid_count_q <= invalid_count_d;
      end
   end

   assign alsu_A         = pins_q.a;
   assign alsu_B         = pins_q.b;
   assign alsu_opcode    = pins_q.opcode;
   assign alsu_cin       = pins_q.cin;
   assign alsu_serial_in = pins_q.serial_in;
   assign alsu_red_op_A  = pins_q.red_op_a;
   assign alsu_red_op_B  = pins_q.red_op_b;
   assign alsu_bypass_A  = pins_q.bypass_a;
   assign alsu_bypass_B  = pins_q.bypass_b;
   assign alsu_direction = pins_q.direction;

   assign rsp_valid     = (state_q == ST_RESP);
   assign rsp_data      = rsp_data_q;
   assign rsp_invalid   = rsp_invalid_q;
   assign rsp_leds_on   = rsp_leds_on_q;
   assign op_count      = op_count_q;
   assign invalid_count = invalid_count_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_alsu_driver.sv
// Bench for alsu_driver: a two-stage registered ALSU stand-in (full adder,
// A-priority bypass) sits behind the driver; responses are scoreboarded.
module tb_alsu_driver;
   import alsu_pkg::*;

   localparam int EXP_W = 24;

   logic clk = 1'b0;
   logic rst;
   logic req_valid, req_ready;
   logic [2:0] req_opcode;
   logic signed [2:0] req_a, req_b;
   logic req_cin, req_serial_in, req_red_op_a, req_red_op_b;
   logic req_bypass_a, req_bypass_b, req_direction;
   logic signed [2:0] alsu_A, alsu_B;
   logic [2:0] alsu_opcode;
   logic alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B;
   logic alsu_bypass_A, alsu_bypass_B, alsu_direction;
   logic signed [5:0] alsu_out;
   logic [15:0] alsu_leds;
   logic rsp_valid, rsp_ready;
   logic signed [5:0] rsp_data;
   logic rsp_invalid, rsp_leds_on;
   logic [7:0] op_count, invalid_count;
   state_e dbg_state;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int acc_edge = 0;
   int rsp_mode = 0;
   int model_op = 0;
   int model_inv = 0;
   logic [EXP_W-1:0] exp_q[$];

   alsu_driver dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
      .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_serial_in(req_serial_in),
      .req_red_op_a(req_red_op_a), .req_red_op_b(req_red_op_b),
      .req_bypass_a(req_bypass_a), .req_bypass_b(req_bypass_b), .req_direction(req_direction),
      .alsu_A(alsu_A), .alsu_B(alsu_B), .alsu_opcode(alsu_opcode), .alsu_cin(alsu_cin),
      .alsu_serial_in(alsu_serial_in), .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
      .alsu_bypass_A(alsu_bypass_A), .alsu_bypass_B(alsu_bypass_B), .alsu_direction(alsu_direction),
      .alsu_out(alsu_out), .alsu_leds(alsu_leds),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_invalid(rsp_invalid), .rsp_leds_on(rsp_leds_on),
      .op_count(op_count), .invalid_count(invalid_count), .dbg_state(dbg_state)
   );

   // ---------------- ALSU stand-in: input stage, then output stage ----------
   logic signed [2:0] sa_a, sa_b;
   logic signed [5:0] sa_ax, sa_bx;
   logic [2:0] sa_opc;
   logic sa_cin, sa_ra, sa_rb, sa_ba, sa_bb, sa_inv;

   assign sa_ax = sa_a;
   assign sa_bx = sa_b;

   alsu_invalid_chk u_sa_chk (.opcode(sa_opc), .red_op_a(sa_ra), .red_op_b(sa_rb), .invalid(sa_inv));

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         sa_a <= '0; sa_b <= '0; sa_opc <= '0; sa_cin <= 1'b0;
         sa_ra <= 1'b0; sa_rb <= 1'b0; sa_ba <= 1'b0; sa_bb <= 1'b0;
         alsu_out <= '0; alsu_leds <= '0;
      end else begin
         sa_a <= alsu_A; sa_b <= alsu_B; sa_opc <= alsu_opcode; sa_cin <= alsu_cin;
         sa_ra <= alsu_red_op_A; sa_rb <= alsu_red_op_B;
         sa_ba <= alsu_bypass_A; sa_bb <= alsu_bypass_B;
         alsu_leds <= sa_inv ? 16'hFFFF : 16'h0000;
         if (sa_inv) alsu_out <= '0;
         else if (sa_ba) alsu_out <= sa_ax;
         else if (sa_bb) alsu_out <= sa_bx;
         else begin
            case (sa_opc)
               OP_OR:   alsu_out <= sa_ra ? {5'b0, |sa_a} : sa_rb ? {5'b0, |sa_b} : (sa_ax | sa_bx);
               OP_XOR:  alsu_out <= sa_ra ? {5'b0, ^sa_a} : sa_rb ? {5'b0, ^sa_b} : (sa_ax ^ sa_bx);
               OP_ADD:  alsu_out <= sa_ax + sa_bx + {5'b0, sa_cin};
               OP_MUL:  alsu_out <= sa_ax * sa_bx;
               default: alsu_out <= '0;
            endcase
         end
      end
   end

   // ---------------- clock / reset / cycle counter --------------------------
   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end
   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------------------------------
   function automatic bit ref_inv(input int opc, input bit ra, input bit rb);
      return (opc >= 6) || ((ra || rb) && (opc >= 2));
   endfunction

   function automatic logic [5:0] ref_out(input int opc, input int a, input int b, input bit cin,
                                          input bit ra, input bit rb, input bit ba, input bit bb);
      int r;
      if (ref_inv(opc, ra, rb)) r = 0;
      else if (ba) r = a;
      else if (bb) r = b;
      else if (opc == 0) r = ra ? ((a != 0) ? 1 : 0) : rb ? ((b != 0) ? 1 : 0) : (a | b);
      else if (opc == 1) r = ra ? ($countones(a & 7) % 2) : rb ? ($countones(b & 7) % 2) : (a ^ b);
      else if (opc == 2) r = a + b + (cin ? 1 : 0);
      else r = a * b;
      return 6'(r);
   endfunction

   // ---------------- check / driver tasks -----------------------------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic rand_req_fields();
      req_opcode = 3'($urandom_range(0, 7));
      req_a = 3'($urandom_range(0, 7));
      req_b = 3'($urandom_range(0, 7));
      {req_cin, req_serial_in, req_red_op_a, req_red_op_b} = 4'($urandom_range(0, 15));
      {req_bypass_a, req_bypass_b, req_direction} = 3'($urandom_range(0, 7));
   endtask

   // Offers one request when the driver is idle; afterwards req_valid stays
   // high with junk fields so any acceptance while busy shows up as an extra op.
   task automatic send_req(input int opc, input int a, input int b, input bit cin, input bit si,
                           input bit ra, input bit rb, input bit ba, input bit bb, input bit dir,
                           input logic [5:0] e_data, input bit e_inv);
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("req_ready_wait", 32'(req_ready), 32'd1);
      req_opcode = 3'(opc); req_a = 3'(a); req_b = 3'(b);
      req_cin = cin; req_serial_in = si; req_red_op_a = ra; req_red_op_b = rb;
      req_bypass_a = ba; req_bypass_b = bb; req_direction = dir;
      req_valid = 1'b1;
      exp_q.push_back({3'(a), 3'(b), 3'(opc), cin, si, ra, rb, ba, bb, dir, e_inv, e_inv, e_data});
      acc_edge = cyc + 1;
      @(negedge clk);
      rand_req_fields();
   endtask

   task automatic send_rand();
      int opc, a, b;
      bit cin, si, ra, rb, ba, bb, dir;
      opc = $urandom_range(0, 7);
      a = $urandom_range(0, 7) - 4;
      b = $urandom_range(0, 7) - 4;
      cin = 1'($urandom_range(0, 1)); si = 1'($urandom_range(0, 1)); dir = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 4) == 0); rb = ($urandom_range(0, 4) == 0);
      ba = ($urandom_range(0, 5) == 0); bb = ($urandom_range(0, 5) == 0);
      if ((opc == 4 || opc == 5) && !(ra || rb)) ra = 1'b1;
      send_req(opc, a, b, cin, si, ra, rb, ba, bb, dir,
               ref_out(opc, a, b, cin, ra, rb, ba, bb), ref_inv(opc, ra, rb));
   endtask

   task automatic wait_drain();
      int n = 0;
      req_valid = 1'b0;
      @(negedge clk);
      while ((exp_q.size() != 0 || !req_ready) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
   endtask

   // ---------------- consumer ready driver ----------------------------------
   initial begin
      rsp_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rsp_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = ($urandom_range(0, 2) != 0);
            default: rsp_ready = 1'b0;
         endcase
      end
   end

   // ---------------- monitor / scoreboard -----------------------------------
   bit prev_valid = 1'b0;
   bit prev_hs = 1'b0;
   logic [7:0] prev_rsp = '0;

   initial forever begin
      logic [EXP_W-1:0] ent;
      @(negedge clk);
      if (!rst) begin
         check("reset_rsp", 32'({req_ready, rsp_valid, rsp_data, rsp_invalid, rsp_leds_on,
                                 op_count, invalid_count}), 32'd0);
         check("reset_pins", 32'({alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_serial_in,
                                  alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B,
                                  alsu_direction}), 32'd0);
         model_op = 0;
         model_inv = 0;
         prev_valid = 1'b0;
         prev_hs = 1'b0;
      end else begin
         check("op_count", 32'(op_count), 32'(model_op));
         check("invalid_count", 32'(invalid_count), 32'(model_inv));
         if (rsp_valid) check("req_ready_busy", 32'(req_ready), 32'd0);
         if (prev_valid && !prev_hs) begin
            check("rsp_hold", 32'({rsp_valid, rsp_invalid, rsp_leds_on, rsp_data}),
                  32'({1'b1, prev_rsp}));
         end else if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
               ent = exp_q[0];
               check("rsp_data", 32'($unsigned(rsp_data)), 32'(ent[5:0]));
               check("rsp_leds_on", 32'(rsp_leds_on), 32'(ent[6]));
               check("rsp_invalid", 32'(rsp_invalid), 32'(ent[7]));
               check("alsu_pins", 32'({alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_serial_in,
                                       alsu_red_op_A, alsu_red_op_B, alsu_bypass_A,
                                       alsu_bypass_B, alsu_direction}), 32'(ent[23:8]));
               check("latency", 32'(cyc - acc_edge), 32'd3);
            end
         end
         if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
            ent = exp_q.pop_front();
            model_op = (model_op + 1) % 256;
            if (ent[7] && model_inv < 255) model_inv++;
         end
         prev_valid = rsp_valid;
         prev_hs = rsp_valid && rsp_ready;
         prev_rsp = {rsp_invalid, rsp_leds_on, rsp_data};
      end
   end

   // ---------------- test sequence ------------------------------------------
   initial begin
      int n;
      rst = 1'b0;
      req_valid = 1'b0;
      req_opcode = '0; req_a = '0; req_b = '0;
      {req_cin, req_serial_in, req_red_op_a, req_red_op_b} = '0;
      {req_bypass_a, req_bypass_b, req_direction} = '0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      check("ready_after_reset", 32'(req_ready), 32'd1);

      // ADD with carry: 3 + 2 + 1
      send_req(2, 3, 2, 1, 0, 0, 0, 0, 0, 0, 6'b000110, 1'b0);
      wait_drain();
      check("op_count_first", 32'(op_count), 32'd1);
      check("invalid_count_first", 32'(invalid_count), 32'd0);

      // MUL: -2 * 3
      send_req(3, -2, 3, 0, 0, 0, 0, 0, 0, 0, 6'b111010, 1'b0);
      // opcode 6 is invalid
      send_req(6, 1, 1, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 1'b1);
      wait_drain();
      check("invalid_count_op6", 32'(invalid_count), 32'd1);
      check("op_count_op6", 32'(op_count), 32'd3);

      // both bypasses, A has priority
      send_req(0, -1, 2, 0, 0, 0, 0, 1, 1, 0, 6'b111111, 1'b0);
      wait_drain();

      // consumer stalls four cycles in RESP while a request is also offered
      rsp_mode = 2;
      send_req(2, 1, -3, 0, 0, 0, 0, 0, 0, 0, 6'b111110, 1'b0);
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("stall_rsp_seen", 32'(rsp_valid), 32'd1);
      repeat (4) begin
         @(negedge clk);
         check("stall_valid", 32'(rsp_valid), 32'd1);
         check("stall_op_count", 32'(op_count), 32'd4);
      end
      rsp_mode = 0;
      wait_drain();
      check("op_count_after_stall", 32'(op_count), 32'd5);

      // reset while the ALSU result is in flight
      send_req(2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 6'b000010, 1'b0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      req_valid = 1'b0;
      exp_q.delete();
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      check("ready_after_mid_reset", 32'(req_ready), 32'd1);
      repeat (6) @(negedge clk);
      check("no_rsp_after_reset", 32'(op_count), 32'd0);

      send_req(3, 3, 3, 0, 0, 0, 0, 0, 0, 0, 6'b001001, 1'b0);
      wait_drain();
      check("op_count_post_reset", 32'(op_count), 32'd1);

      // randomized traffic with a random consumer; enough ops to wrap op_count
      rsp_mode = 1;
      repeat (270) send_rand();
      wait_drain();
      rsp_mode = 0;
      check("op_count_wrap", 32'(op_count), 32'((1 + 270) % 256));

      // drive invalid_count into saturation
      repeat (260) send_req(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 1'b1);
      wait_drain();
      check("invalid_count_sat", 32'(invalid_count), 32'd255);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
